// File: rtl/mem_xfer_pkg.sv
// Shared types and defaults for the memory-to-memory transfer sequencer.
package mem_xfer_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } xfer_state_t;

endpackage

// File: rtl/mem_xfer_ctrl_addr_counter.sv
// Wrapping address counter with async clear, sync clear and increment enable.
module addr_counter
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (clr)   count <= '0;
    else if (inc)   count <= count + ADDR_W'(1);
  end

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Load-then-copy sequencer: fills memory A from the source, then copies A into B.
// Optional stall input Hold is built only when XFER_HOLD_EN is defined.
//
// state | meaning
// IDLE  | waiting for Start
// LOAD  | writing source words into A, one per cycle
// XFER  | sweeping A read addresses; B written one cycle behind
// DRAIN | final B write for the last A read
// DONE  | one-cycle completion pulse
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
`ifdef XFER_HOLD_EN
  input  logic              Hold,
`endif
  output logic [ADDR_W-1:0] AddrA,
  output logic [ADDR_W-1:0] AddrB,
  output logic              WEA,
  output logic              WEB,
  output logic              IncA,
  output logic              IncB,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  xfer_state_t state, state_nxt;
  logic        wr_pend;
  logic        hold;
  logic        stall;
  logic        start_acc;

`ifdef XFER_HOLD_EN
  assign hold = Hold;
`else
  assign hold = 1'b0;
`endif

  // Hold only matters while the sequence is actively moving data.
  assign stall     = hold && (state == LOAD || state == XFER || state == DRAIN);
  assign start_acc = (state == IDLE) && Start;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)                wr_pend <= 1'b0;
    else if (!stall) begin
      if (state == XFER)       wr_pend <= 1'b1;
      else                     wr_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    Busy      = (state != IDLE);
    Done      = (state == DONE);
    WEA       = 1'b0;
    IncA      = 1'b0;
    WEB       = 1'b0;
    IncB      = 1'b0;
    case (state)
      IDLE:  if (Start) state_nxt = LOAD;
      LOAD: begin
        WEA  = !stall;
        IncA = !stall;
        if (!stall && AddrA == LAST) state_nxt = XFER;
      end
      XFER: begin
        IncA = !stall;
        WEB  = wr_pend && !stall;
        IncB = wr_pend && !stall;
        if (!stall && AddrA == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        WEB  = wr_pend && !stall;
        IncB = wr_pend && !stall;
        if (!stall) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  addr_counter #(.ADDR_W(ADDR_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (Reset),
    .clr   (start_acc),
    .inc   (IncA),
    .count (AddrA)
  );

  addr_counter #(.ADDR_W(ADDR_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (Reset),
    .clr   (start_acc),
    .inc   (IncB),
    .count (AddrB)
  );

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Self-checking bench for mem_xfer_ctrl: vector table, corner sequences, random Start vs model.
module tb_mem_xfer_ctrl;

  localparam int AW = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          Reset, Start, Hold;
  logic [AW-1:0] AddrA, AddrB;
  logic          WEA, WEB, IncA, IncB, Busy, Done;

  always #5 clk = ~clk;

  mem_xfer_ctrl #(.ADDR_W(AW), .DEPTH(D)) dut (
    .clk   (clk),
    .Reset (Reset),
    .Start (Start),
`ifdef XFER_HOLD_EN
    .Hold  (Hold),
`endif
    .AddrA (AddrA),
    .AddrB (AddrB),
    .WEA   (WEA),
    .WEB   (WEB),
    .IncA  (IncA),
    .IncB  (IncB),
    .Busy  (Busy),
    .Done  (Done)
  );

  // Memory A with registered read; read data is held while Hold is asserted.
  logic [7:0] mem_a [D];
  logic [7:0] mem_b [D];
  logic [7:0] src   [D];
  logic [7:0] rd_q;

  always @(posedge clk) begin
    if (WEA) mem_a[AddrA] <= src[AddrA];
    rd_q <= Hold ? rd_q : mem_a[AddrA];
    if (WEB) mem_b[AddrB] <= rd_q;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {Busy, Done, WEA, WEB, IncA, IncB, AddrA, AddrB};
  endfunction

  // Expected outputs from the cycle offset t since the accepting edge.
  function automatic logic [11:0] model_out(input bit act, input int t);
    logic wea, web, inca, busy, done;
    int   aa, ab;
    busy = act;
    wea  = act && t < D;
    inca = act && t < 2 * D;
    web  = act && t > D && t <= 2 * D;
    done = act && t == 2 * D + 1;
    aa   = (act && t < 2 * D) ? t % D : 0;
    ab   = web ? t - D - 1 : 0;
    return {busy, done, wea, web, inca, web, aa[AW-1:0], ab[AW-1:0]};
  endfunction

  typedef struct {
    logic        start;
    logic [11:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic busy, input logic done,
                              input logic wea, input logic web, input logic inca,
                              input logic incb, input int aa, input int ab);
    vec_t v;
    v.start = st;
    v.exp   = {busy, done, wea, web, inca, incb, aa[AW-1:0], ab[AW-1:0]};
    return v;
  endfunction

  task automatic check_mem(input string tag);
    for (int k = 0; k < D; k++)
      chk($sformatf("%s_b%0d", tag, k), {8'h0, mem_b[k]}, {8'h0, src[k]});
  endtask

  task automatic run_busy(input string tag, input int exp_len);
    int cnt, dones;
    bit seen_end;
    cnt = 0; dones = 0; seen_end = 0;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!Busy) begin
        seen_end = 1;
        break;
      end
      cnt++;
      if (Done) dones++;
      @(negedge clk);
    end
    chk({tag, "_end"}, 16'(seen_end), 16'd1);
    chk({tag, "_busy_len"}, 16'(cnt), 16'(exp_len));
    chk({tag, "_done_cnt"}, 16'(dones), 16'd1);
  endtask

  vec_t tbl [21];
  bit   m_act;
  int   m_t;

  initial begin
    tbl[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tbl[1 + i] = mk(i == 2, 1, 0, 1, 0, 1, 0, i, 0);
    tbl[9] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) tbl[10 + i] = mk(i == 2, 1, 0, 0, 1, 1, 1, i + 1, i);
    tbl[17] = mk(0, 1, 0, 0, 1, 0, 1, 0, 7);
    tbl[18] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(0, 1, 0, 1, 0, 1, 0, 0, 0);

    Reset = 1'b0; Start = 1'b0; Hold = 1'b0;
    for (int k = 0; k < D; k++) src[k] = 8'(8'h11 * k);
    repeat (2) @(negedge clk);
    chk("reset_outputs", {4'h0, obs()}, 16'h0);
    Reset = 1'b1;
    @(negedge clk);

    // Full sequence with ignored Starts in LOAD, XFER and DONE, then a restart.
    for (int r = 0; r < 21; r++) begin
      chk($sformatf("vec%0d", r), {4'h0, obs()}, {4'h0, tbl[r].exp});
      if (r == 18) check_mem("vec");
      Start = tbl[r].start;
      @(negedge clk);
    end
    Start = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_after_vec", {4'h0, obs()}, 16'h0);

    // Asynchronous reset in the middle of XFER.
    for (int k = 0; k < D; k++) src[k] = 8'($urandom);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_addr_a", {13'h0, AddrA}, 16'd3);
    chk("mid_web", {15'h0, WEB}, 16'd1);
    Reset = 1'b0;
    #1;
    chk("mid_reset_outputs", {4'h0, obs()}, 16'h0);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    run_busy("post_reset", 18);
    check_mem("post_reset");

`ifdef XFER_HOLD_EN
    begin
      int cnt;
      for (int k = 0; k < D; k++) src[k] = 8'($urandom);
      cnt = 0;
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      for (int i = 0; i < 12; i++) begin
        cnt += int'(Busy);
        @(negedge clk);
      end
      Hold = 1'b1;
      for (int h = 0; h < 3; h++) begin
        #1;
        chk($sformatf("hold%0d_addr_a", h), {13'h0, AddrA}, 16'd4);
        chk($sformatf("hold%0d_addr_b", h), {13'h0, AddrB}, 16'd3);
        chk($sformatf("hold%0d_web", h), {15'h0, WEB}, 16'd0);
        cnt += int'(Busy);
        @(negedge clk);
      end
      Hold = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (!Busy) break;
        cnt++;
        @(negedge clk);
      end
      chk("hold_busy_len", 16'(cnt), 16'd21);
      check_mem("hold");
    end
`endif

    // Random Start traffic, with a continuous-Start stretch at the end.
    m_act = 0;
    m_t   = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      chk($sformatf("rand%0d", cyc), {4'h0, obs()}, {4'h0, model_out(m_act, m_t)});
      if (WEA && WEB) chk("we_overlap", 16'd1, 16'd0);
      if (m_act && m_t == 2 * D + 1) check_mem($sformatf("rand%0d", cyc));
      Start = (cyc >= 320) ? 1'b1 : (($urandom % 3) == 0);
      if (!m_act && Start)
        for (int k = 0; k < D; k++) src[k] = 8'($urandom);
      if (!m_act) begin
        if (Start) begin
          m_act = 1;
          m_t   = 0;
        end
      end else if (m_t == 2 * D + 1) begin
        m_act = 0;
      end else begin
        m_t++;
      end
      @(negedge clk);
    end
    Start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
